// File: rtl/sample_ram_read_sched_if.sv
`default_nettype none
// ============================================================================
//  Module      : sample_ram_read_sched_if
//  Description : Consumer-side bus of the sample RAM read scheduler
//                (request/grant plus shared data with per-consumer valid/ready).
//  Revision    : 1.0 - initial release
// ============================================================================
interface sample_ram_read_sched_if #(
    parameter int NUM_REQ = 2
);
    logic [NUM_REQ-1:0] req_i;
    logic [NUM_REQ-1:0] gnt_o;
    logic [NUM_REQ-1:0] valid_o;
    logic [NUM_REQ-1:0] ready_i;
    logic signed [23:0] data_o;

    modport master (
        input  req_i,
        input  ready_i,
        output gnt_o,
        output valid_o,
        output data_o
    );

    modport slave (
        output req_i,
        output ready_i,
        input  gnt_o,
        input  valid_o,
        input  data_o
    );
endinterface
`default_nettype wire

// File: rtl/sample_ram_read_sched.sv
`default_nettype none
// ============================================================================
//  Module      : sample_ram_read_sched
//  Description : Grants a full sample buffer to one consumer by round-robin
//                and plays it out word by word, then releases it to the sampler.
//                Optional stall timeout: define SAMPLE_SCHED_TIMEOUT_EN.
//  Revision    : 1.0 - initial release
// ============================================================================
module sample_ram_read_sched #(
    parameter int NUM_REQ     = 2,
    parameter int BUF_DEPTH   = 256,
    parameter int ADDR_W      = 8,
    parameter int TIMEOUT_CYC = 4096
) (
    input  wire                 clk_i,
    input  wire                 rst_ni,
    input  wire                 buf_ready_i,
    output logic                buf_release_o,
    output logic                ram_rd_en_o,
    output logic [ADDR_W-1:0]   ram_rd_addr_o,
    input  wire signed [23:0]   ram_rd_data_i,
    sample_ram_read_sched_if.master cons,
    output logic                busy_o,
    output logic                err_o
);

    localparam int                LG        = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;
    localparam logic [ADDR_W-1:0] LAST_ADDR = ADDR_W'(BUF_DEPTH - 1);

    generate
        if (NUM_REQ < 2 || NUM_REQ > 4) begin : g_bad_num_req
            $error("NUM_REQ must be in 2..4");
        end
        if (BUF_DEPTH < 2 || BUF_DEPTH > (2 ** ADDR_W)) begin : g_bad_depth
            $error("BUF_DEPTH must be in 2..2^ADDR_W");
        end
        if (TIMEOUT_CYC < 1) begin : g_bad_timeout
            $error("TIMEOUT_CYC must be at least 1");
        end
    endgenerate

    typedef enum logic [2:0] {
        S_IDLE  = 3'd0,
        S_ISSUE = 3'd1,
        S_WAIT  = 3'd2,
        S_HOLD  = 3'd3,
        S_DONE  = 3'd4
    } state_e;

    state_e             state_q;
    logic [LG-1:0]      gidx_q;
    logic [LG-1:0]      last_gnt_q;
    logic [NUM_REQ-1:0] gnt_q;
    logic [NUM_REQ-1:0] valid_q;
    logic signed [23:0] data_q;
    logic [ADDR_W-1:0]  addr_q;
    logic [ADDR_W-1:0]  ram_rd_addr_q;
    logic               ram_rd_en_q;
    logic               buf_release_q;
    logic               busy_q;
    logic [LG-1:0]      winner_d;

`ifdef SAMPLE_SCHED_TIMEOUT_EN
    localparam int TMO_W = $clog2(TIMEOUT_CYC + 1);
    localparam logic [TMO_W-1:0] TMO_LAST = TMO_W'(TIMEOUT_CYC - 1);
    logic [TMO_W-1:0] tmo_q;
    logic             err_q;
`endif

    // Round-robin: first set request scanning upward from last_gnt+1 with wrap.
    always_comb begin
        int  idx;
        logic found;
        winner_d = '0;
        found    = 1'b0;
        idx      = 0;
        for (int i = 1; i <= NUM_REQ; i++) begin
            idx = (int'(last_gnt_q) + i) % NUM_REQ;
            if (!found && cons.req_i[idx]) begin
                found    = 1'b1;
                winner_d = LG'(idx);
            end
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q       <= S_IDLE;
            gidx_q        <= '0;
            last_gnt_q    <= LG'(NUM_REQ - 1);
            gnt_q         <= '0;
            valid_q       <= '0;
            data_q        <= '0;
            addr_q        <= '0;
            ram_rd_addr_q <= '0;
            ram_rd_en_q   <= 1'b0;
            buf_release_q <= 1'b0;
            busy_q        <= 1'b0;
`ifdef SAMPLE_SCHED_TIMEOUT_EN
            tmo_q         <= '0;
            err_q         <= 1'b0;
`endif
        end else begin
            ram_rd_en_q   <= 1'b0;
            buf_release_q <= 1'b0;
            case (state_q)
                S_IDLE: begin
                    if (buf_ready_i && (|cons.req_i)) begin
                        gidx_q        <= winner_d;
                        gnt_q         <= NUM_REQ'(1) << winner_d;
                        ram_rd_en_q   <= 1'b1;
                        ram_rd_addr_q <= addr_q;
                        busy_q        <= 1'b1;
                        state_q       <= S_ISSUE;
                    end
                end
                S_ISSUE: begin
                    state_q <= S_WAIT;
                end
                S_WAIT: begin
                    data_q  <= ram_rd_data_i;
                    valid_q <= gnt_q;
                    state_q <= S_HOLD;
                end
                S_HOLD: begin
                    if (cons.ready_i[gidx_q]) begin
                        valid_q <= '0;
`ifdef SAMPLE_SCHED_TIMEOUT_EN
                        tmo_q   <= '0;
`endif
                        if (addr_q == LAST_ADDR) begin
                            buf_release_q <= 1'b1;
                            gnt_q         <= '0;
                            state_q       <= S_DONE;
                        end else begin
                            addr_q        <= addr_q + 1'b1;
                            ram_rd_addr_q <= addr_q + 1'b1;
                            ram_rd_en_q   <= 1'b1;
                            state_q       <= S_ISSUE;
                        end
                    end
`ifdef SAMPLE_SCHED_TIMEOUT_EN
                    else if (tmo_q == TMO_LAST) begin
                        // Stalled consumer: abandon the buffer so the sampler can proceed.
                        tmo_q         <= '0;
                        err_q         <= 1'b1;
                        valid_q       <= '0;
                        gnt_q         <= '0;
                        buf_release_q <= 1'b1;
                        state_q       <= S_DONE;
                    end else begin
                        tmo_q <= tmo_q + 1'b1;
                    end
`endif
                end
                S_DONE: begin
                    last_gnt_q <= gidx_q;
                    addr_q     <= '0;
                    busy_q     <= 1'b0;
                    state_q    <= S_IDLE;
                end
                default: begin
                    state_q <= S_IDLE;
                end
            endcase
        end
    end

    assign cons.gnt_o    = gnt_q;
    assign cons.valid_o  = valid_q;
    assign cons.data_o   = data_q;
    assign ram_rd_en_o   = ram_rd_en_q;
    assign ram_rd_addr_o = ram_rd_addr_q;
    assign buf_release_o = buf_release_q;
    assign busy_o        = busy_q;
`ifdef SAMPLE_SCHED_TIMEOUT_EN
    assign err_o         = err_q;
`else
    assign err_o         = 1'b0;
`endif

endmodule
`default_nettype wire

// File: tb/tb_sample_ram_read_sched.sv
`default_nettype none
// ============================================================================
//  Module      : tb_sample_ram_read_sched
//  Description : Directed self-checking bench for sample_ram_read_sched
//                (BUF_DEPTH=4, two consumers, TIMEOUT_CYC=16).
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_sample_ram_read_sched;

    localparam int NUM_REQ   = 2;
    localparam int BUF_DEPTH = 4;
    localparam int ADDR_W    = 2;

    logic               clk;
    logic               rst_n;
    logic               buf_ready;
    logic               buf_release;
    logic               ram_rd_en;
    logic [ADDR_W-1:0]  ram_rd_addr;
    logic signed [23:0] ram_q;
    logic               busy;
    logic               err;
    logic signed [23:0] mem [4];

    int n_vec = 0;
    int n_err = 0;

    sample_ram_read_sched_if #(.NUM_REQ(NUM_REQ)) cif ();

    sample_ram_read_sched #(
        .NUM_REQ    (NUM_REQ),
        .BUF_DEPTH  (BUF_DEPTH),
        .ADDR_W     (ADDR_W),
        .TIMEOUT_CYC(16)
    ) dut (
        .clk_i        (clk),
        .rst_ni       (rst_n),
        .buf_ready_i  (buf_ready),
        .buf_release_o(buf_release),
        .ram_rd_en_o  (ram_rd_en),
        .ram_rd_addr_o(ram_rd_addr),
        .ram_rd_data_i(ram_q),
        .cons         (cif),
        .busy_o       (busy),
        .err_o        (err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // One-cycle-latency RAM read port
    always @(posedge clk) begin
        if (ram_rd_en) ram_q <= mem[ram_rd_addr];
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_vec++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic chk_all_zero(input string tag);
        chk({tag, ".gnt"},   32'(cif.gnt_o),   32'd0);
        chk({tag, ".valid"}, 32'(cif.valid_o), 32'd0);
        chk({tag, ".en"},    32'(ram_rd_en),   32'd0);
        chk({tag, ".addr"},  32'(ram_rd_addr), 32'd0);
        chk({tag, ".data"},  {8'd0, cif.data_o}, 32'd0);
        chk({tag, ".rel"},   32'(buf_release), 32'd0);
        chk({tag, ".busy"},  32'(busy),        32'd0);
        chk({tag, ".err"},   32'(err),         32'd0);
    endtask

    // Called at the negedge right after the issue edge; returns in HOLD.
    task automatic expect_word(input string tag, input int a,
                               input logic signed [23:0] d, input logic [1:0] g);
        chk({tag, ".en"},   32'(ram_rd_en),   32'd1);
        chk({tag, ".addr"}, 32'(a[ADDR_W-1:0]) == 32'(ram_rd_addr) ? 32'(ram_rd_addr) : 32'(ram_rd_addr),
            32'(a));
        chk({tag, ".gnt"},  32'(cif.gnt_o),   32'(g));
        chk({tag, ".busy"}, 32'(busy),        32'd1);
        @(negedge clk);
        chk({tag, ".en_off"},   32'(ram_rd_en),   32'd0);
        chk({tag, ".valid_lo"}, 32'(cif.valid_o), 32'd0);
        @(negedge clk);
        chk({tag, ".valid"}, 32'(cif.valid_o), 32'(g));
        chk({tag, ".data"},  {8'd0, cif.data_o}, {8'd0, d});
    endtask

    // Full pass with ready held high; buf_ready left asserted on return (IDLE).
    task automatic full_pass(input string tag, input logic [1:0] g);
        buf_ready = 1'b1;
        @(negedge clk);
        expect_word({tag, ".w0"}, 0, 24'sd10, g);
        @(negedge clk);
        expect_word({tag, ".w1"}, 1, -24'sd20, g);
        @(negedge clk);
        expect_word({tag, ".w2"}, 2, 24'sd30, g);
        @(negedge clk);
        expect_word({tag, ".w3"}, 3, -24'sd40, g);
        @(negedge clk);
        chk({tag, ".rel"},      32'(buf_release), 32'd1);
        chk({tag, ".rel_gnt"},  32'(cif.gnt_o),   32'd0);
        chk({tag, ".rel_busy"}, 32'(busy),        32'd1);
        @(negedge clk);
        chk({tag, ".idle_rel"},  32'(buf_release), 32'd0);
        chk({tag, ".idle_busy"}, 32'(busy),        32'd0);
        chk({tag, ".idle_en"},   32'(ram_rd_en),   32'd0);
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not finish (observed timeout, expected $finish)");
        $fatal(1);
    end

    initial begin
        mem[0] = 24'sd10;
        mem[1] = -24'sd20;
        mem[2] = 24'sd30;
        mem[3] = -24'sd40;
        rst_n     = 1'b0;
        buf_ready = 1'b0;
        cif.req_i   = '0;
        cif.ready_i = '0;

        // Reset state
        #12;
        chk_all_zero("rst");
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);

        // Single pass to consumer 0
        cif.req_i   = 2'b01;
        cif.ready_i = 2'b01;
        full_pass("p1", 2'b01);
        buf_ready = 1'b0;
        @(negedge clk);

        // Backpressure, non-granted ready, request drop mid-pass
        cif.req_i   = 2'b01;
        cif.ready_i = 2'b10;
        buf_ready   = 1'b1;
        @(negedge clk);
        expect_word("bp.w0", 0, 24'sd10, 2'b01);
        cif.req_i = 2'b00;
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            chk("bp.valid", 32'(cif.valid_o), 32'd1);
            chk("bp.data",  {8'd0, cif.data_o}, 32'd10);
            chk("bp.en",    32'(ram_rd_en), 32'd0);
            chk("bp.gnt",   32'(cif.gnt_o), 32'd1);
            chk("bp.err",   32'(err), 32'd0);
        end
        cif.ready_i = 2'b11;
        @(negedge clk);
        expect_word("bp.w1", 1, -24'sd20, 2'b01);
        @(negedge clk);
        expect_word("bp.w2", 2, 24'sd30, 2'b01);
        @(negedge clk);
        expect_word("bp.w3", 3, -24'sd40, 2'b01);
        @(negedge clk);
        chk("bp.rel", 32'(buf_release), 32'd1);
        buf_ready = 1'b0;
        @(negedge clk);
        chk("bp.idle_busy", 32'(busy), 32'd0);

        // Asynchronous reset while holding word 2
        cif.req_i   = 2'b01;
        cif.ready_i = 2'b01;
        buf_ready   = 1'b1;
        @(negedge clk);
        expect_word("ar.w0", 0, 24'sd10, 2'b01);
        @(negedge clk);
        expect_word("ar.w1", 1, -24'sd20, 2'b01);
        @(negedge clk);
        expect_word("ar.w2", 2, 24'sd30, 2'b01);
        #2 rst_n = 1'b0;
        #1;
        chk_all_zero("ar.mid");
        buf_ready = 1'b0;
        cif.req_i = 2'b00;
        @(negedge clk);
        chk("ar.rel", 32'(buf_release), 32'd0);
        rst_n = 1'b1;
        @(negedge clk);

        // Round-robin from reset: 0, 1, 0 back to back
        cif.req_i   = 2'b11;
        cif.ready_i = 2'b11;
        full_pass("rr0", 2'b01);
        full_pass("rr1", 2'b10);
        full_pass("rr2", 2'b01);
        buf_ready = 1'b0;
        @(negedge clk);
        chk("rr.idle_gnt", 32'(cif.gnt_o), 32'd0);

`ifdef SAMPLE_SCHED_TIMEOUT_EN
        // Stall timeout
        cif.req_i   = 2'b01;
        cif.ready_i = 2'b00;
        buf_ready   = 1'b1;
        @(negedge clk);
        expect_word("to.w0", 0, 24'sd10, 2'b01);
        for (int i = 0; i < 15; i++) begin
            @(negedge clk);
            chk("to.stall_rel", 32'(buf_release), 32'd0);
            chk("to.stall_val", 32'(cif.valid_o), 32'd1);
        end
        @(negedge clk);
        chk("to.rel",   32'(buf_release), 32'd1);
        chk("to.gnt",   32'(cif.gnt_o),   32'd0);
        chk("to.valid", 32'(cif.valid_o), 32'd0);
        chk("to.err",   32'(err),         32'd1);
        buf_ready = 1'b0;
        @(negedge clk);
        chk("to.rel_off",  32'(buf_release), 32'd0);
        chk("to.err_stky", 32'(err),         32'd1);
        chk("to.busy",     32'(busy),        32'd0);
`else
        chk("final.err", 32'(err), 32'd0);
`endif

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
`default_nettype wire
